// File: rtl/ov_cfg_seq.sv
// OV sensor configuration sequencer: walks a {reg_addr, reg_val} table ROM and
// issues one SCCB register write per entry, with delay/end markers and NACK retry.
module ov_cfg_seq #(
  parameter int unsigned TBL_AW    = 8,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned MS_US     = 1000,
  parameter int unsigned GAP_US    = 100
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              iic_req,
  output logic [7:0]        iic_dev,
  output logic [7:0]        iic_reg,
  output logic [7:0]        iic_dat,
  input  logic              iic_done,
  input  logic              iic_nack,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int unsigned CW = 8 + $clog2(MS_US);
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, DECODE, WRITE, GAP, DELAY, DONE, ERR
  } state_t;

  state_t            r_state;
  logic [TBL_AW-1:0] r_idx;
  logic [RW-1:0]     r_retry;
  logic [15:0]       r_entry;
  logic [CW-1:0]     r_cnt;
  logic              r_req;
  logic [7:0]        r_iic_reg;
  logic [7:0]        r_iic_dat;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [TBL_AW-1:0] r_err_idx;

  logic [7:0] w_ent_reg;
  logic [7:0] w_ent_val;
  logic       w_adv;
  logic       w_finish;

  assign w_ent_reg = r_entry[15:8];
  assign w_ent_val = r_entry[7:0];

  // Step to the next entry (or finish) is decided here once and applied after
  // the per-state updates so every state shares the same end-of-table handling.
  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      DECODE:  w_adv = (w_ent_reg == 8'hFE) && (w_ent_val == '0);
      WRITE:   w_adv = iic_done && !iic_nack;
      DELAY:   w_adv = (r_cnt == '0);
      default: w_adv = 1'b0;
    endcase
    w_finish = ((r_state == DECODE) && (w_ent_reg == 8'hFF)) ||
               (w_adv && (r_idx == '1));
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_entry   <= '0;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_iic_reg <= '0;
      r_iic_dat <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state   <= FETCH;
            r_idx     <= '0;
            r_retry   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_entry <= tbl_data;
          r_state <= DECODE;
        end
        DECODE: begin
          if (w_ent_reg == 8'hFE) begin
            if (w_ent_val != '0) begin
              r_cnt   <= CW'(w_ent_val) * CW'(MS_US);
              r_state <= DELAY;
            end
          end else if (w_ent_reg != 8'hFF) begin
            r_iic_reg <= w_ent_reg;
            r_iic_dat <= w_ent_val;
            r_req     <= 1'b1;
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          if (iic_done) begin
            r_req <= 1'b0;
            if (!iic_nack) begin
              r_retry <= '0;
            end else if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + RW'(1);
              r_cnt   <= CW'(GAP_US);
              r_state <= GAP;
            end else begin
              r_err_idx <= r_idx;
              r_err     <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ERR;
            end
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_req   <= 1'b1;
            r_state <= WRITE;
          end else if (pluse_us) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DELAY: begin
          if ((r_cnt != '0) && pluse_us) r_cnt <= r_cnt - CW'(1);
        end
        default: r_state <= IDLE;
      endcase

      if (w_finish) begin
        r_state <= DONE;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_adv) begin
        r_idx   <= r_idx + TBL_AW'(1);
        r_state <= FETCH;
      end
    end
  end

  assign tbl_addr = r_idx;
  assign iic_req  = r_req;
  assign iic_dev  = DEV_ADDR;
  assign iic_reg  = r_iic_reg;
  assign iic_dat  = r_iic_dat;
  assign cfg_busy = r_busy;
  assign cfg_done = r_done;
  assign cfg_err  = r_err;
  assign err_idx  = r_err_idx;

endmodule
